// File: rtl/serial_circular_right_rotator.sv
// Serial circular right rotator.
// Accepts one word plus a rotate amount. It rotates the word right by one bit
// position per clock cycle, then holds the result until downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid, data and shift stable until that edge.
// The receiver may raise or drop ready freely. in_ready is high only in IDLE,
// and out_valid is high only in DONE. There is no skid path, so a word cannot
// be accepted in the same cycle that a result is taken.
module serial_circular_right_rotator #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_ZERO = '0;
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  state_t         state;
  logic [N-1:0]   data_q;
  logic [W-1:0]   cnt_q;
  // armed is low during reset and goes high on the first clock edge after
  // reset is released. While it is low, in_ready stays low even though the
  // state is already IDLE.
  logic           armed_q;

  // Handshake outputs are decoded straight from the state register.
  assign in_ready  = armed_q && (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_q;

  // Main FSM: load on accept, rotate right once per cycle, then hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q <= in_data;
            cnt_q  <= in_shift;
            if (in_shift == CNT_ZERO) begin
              state <= DONE;
            end else begin
              state <= ROTATE;
            end
          end
        end
        ROTATE: begin
          // Single-bit rotate right: the LSB wraps around to the MSB.
          data_q <= {data_q[0], data_q[N-1:1]};
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_circular_right_rotator.sv
// Directed and randomized bench for serial_circular_right_rotator (N=8).
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point.
module tb_serial_circular_right_rotator;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [W-1:0] in_shift;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  serial_circular_right_rotator #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Clock: period of 10 time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference left rotation, built from a doubled word. The result of the DUT's
  // right rotation must undo it.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
    logic [2*N-1:0] t;
    t = {x, x} << s;
    return t[2*N-1:N];
  endfunction

  // Sends one word and checks the latency and the result. The result is held
  // for 'hold' cycles with out_ready low before it is taken. During the busy
  // period, in_valid, in_data and out_ready are toggled when 'noise' is set.
  task automatic run_word(input logic [N-1:0] d, input int s, input logic [N-1:0] exp,
                          input int hold, input bit noise);
    int cycles;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check("ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_shift  = W'(s);
    out_ready = 1'b0;
    step();
    cycles = 1;
    in_valid = 1'b0;
    check("ready_drops_after_accept", in_ready, 0);
    while (!out_valid && cycles < 40) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = N'($urandom_range(0, 255));
        in_shift  = W'($urandom_range(0, 7));
        out_ready = 1'($urandom_range(0, 1));
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", cycles, s + 1);
    check("result", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      in_data = N'($urandom_range(0, 255));
      step();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp);
      check("hold_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("taken_valid_low", out_valid, 0);
    check("taken_back_idle", in_ready, 1);
  endtask

  initial begin
    logic [N-1:0] orig;
    int s;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    out_ready = 1'b0;

    // Reset state and release timing.
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    #2 rst_n = 1'b1;
    #1 check("release_ready_before_edge", in_ready, 0);
    step();
    check("release_ready_after_edge", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Directed vectors.
    run_word(8'hA3, 3, 8'h74, 0, 1'b0);
    run_word(8'h5A, 0, 8'h5A, 0, 1'b0);
    run_word(8'h01, 7, 8'h02, 5, 1'b0);
    run_word(8'hC3, 4, 8'h3C, 1, 1'b1);
    run_word(8'h81, 1, 8'hC0, 0, 1'b1);

    // Asynchronous reset pulse in the middle of rotating 8'hFF by 5.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_shift = 3'd5;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_out_data", out_data, 0);
    #3 rst_n = 1'b1;
    #1 check("async_release_before_edge", in_ready, 0);
    step();
    check("async_release_after_edge", in_ready, 1);
    check("async_no_output", out_valid, 0);
    run_word(8'h80, 1, 8'h40, 0, 1'b0);

    // Randomized inverse check with backpressure and input noise.
    for (int i = 0; i < 1000; i++) begin
      orig = N'($urandom_range(0, 255));
      s    = $urandom_range(0, N - 1);
      run_word(rotl(orig, s), s, orig, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_circular_right_rotator.md
SERIAL_CIRCULAR_RIGHT_ROTATOR -- requirements
Module: serial_circular_right_rotator

Interface
REQ-001 Parameter N, default 8: data word width in bits, N >= 2.
REQ-002 Parameter W, default $clog2(N): width of the shift-amount field.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers in_data/in_shift.
REQ-006 in_ready  output  1  block can accept a new word.
REQ-007 in_data  input  N  word to rotate.
REQ-008 in_shift  input  W  rotate-right amount.
REQ-009 out_valid  output  1  out_data holds a finished result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  N  rotated word.

Function
REQ-012 The block SHALL rotate in_data right circularly by in_shift bit positions, i.e. result = {d[k-1:0], d[N-1:k]} for k = in_shift mod N. This is the inverse of a left rotation by the same amount.
REQ-013 Rotation SHALL be serial: one bit position per clock cycle, using a single 1-bit rotate-right of an internal N-bit data register.
REQ-014 The FSM SHALL have exactly three states: IDLE, ROTATE, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE. Both are decoded from the state register with no extra registering.
REQ-016 Accept in IDLE (in_valid && in_ready at a rising edge):
  - data register <= in_data;
  - counter <= in_shift;
  - next state = DONE if in_shift == 0, else ROTATE.
REQ-017 Each ROTATE cycle:
  - data register <= rotate-right-by-1 of itself;
  - counter <= counter - 1;
  - when counter == 1, next state = DONE.
REQ-018 Latency: out_valid SHALL rise exactly k+1 cycles after the accepting edge, where k = in_shift as presented (no modulo reduction of the count). in_shift >= N costs in_shift cycles and still yields the rotation mod N.
REQ-019 In DONE, out_data and out_valid SHALL hold stable until out_ready is sampled high. The next state is then IDLE.
REQ-020 There SHALL be no skid path: a new word is not accepted in the cycle out_ready completes a result. Maximum throughput is one word per k+2 cycles.
REQ-021 in_valid SHALL be ignored outside IDLE, and in_data/in_shift changes outside IDLE SHALL have no effect.
REQ-022 out_data SHALL always drive the data register directly. Its value is defined only while out_valid = 1.
REQ-023 out_ready outside DONE SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately, without waiting for clk, force:
  - state = IDLE;
  - data register = 0;
  - counter = 0;
  - out_valid = 0;
  - in_ready = 0.
REQ-025 While rst_n is low, in_ready SHALL be 0. From the first rising edge after rst_n deasserts, in_ready SHALL be 1.
REQ-026 Reset asserted in ROTATE or DONE SHALL discard the in-flight word with no output produced. The next accepted word SHALL be processed normally.

Verification
REQ-027 N=8, in_data=8'hA3, in_shift=3 -> in_ready drops the next cycle; out_valid rises 4 cycles after the accepting edge; out_data=8'h74.
REQ-028 N=8, in_data=8'h5A, in_shift=0 -> out_valid rises 1 cycle after accept; out_data=8'h5A.
REQ-029 N=8, in_data=8'h01, in_shift=7 -> out_data=8'h02 after 8 cycles. Then hold out_ready=0 for 5 cycles -> out_data, out_valid=1 and in_ready=0 stay stable; raise out_ready -> IDLE and in_ready=1 the next cycle.
REQ-030 Pulse rst_n low asynchronously, mid-cycle, during ROTATE of 8'hFF with shift 5:
  - out_valid=0 and in_ready=0 immediately, before the next clk edge;
  - after release, in_ready=1 at the next rising edge;
  - a fresh 8'h80 with shift 1 -> 8'h40.
REQ-031 Randomized inverse check, 1000 words with random out_ready backpressure: feed a word left-rotated by s, with in_shift=s -> out_data equals the original word, and latency equals s+1 cycles in every case.
